// File: rtl/imem_loader.sv
// Byte-stream program loader: fills instruction memory from a framed,
// XOR-checksummed stream and holds the CPU in reset until the image verifies.
module imem_loader #(
  parameter int SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [16:0] SIZE_W = 17'(SIZE);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [23:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        crst_q, crst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        acc;
  logic [15:0] n;

  assign in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign acc = in_valid & in_ready;
  assign n = {in_data, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    xor_d   = xor_q;
    word_d  = word_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    crst_d  = crst_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_HDR0: begin
        if (acc) begin
          cnt_d[7:0] = in_data;
          xor_d      = xor_q ^ in_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (acc) begin
          xor_d = xor_q ^ in_data;
          cnt_d = n;
          if ({1'b0, n} > SIZE_W) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          xor_d  = xor_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          // earlier bytes shift down so byte 0 lands in bits [7:0]
          word_d = {in_data, word_q[23:8]};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = {14'b0, idx_q, 2'b00};
            wdata_d = {in_data, word_q};
            idx_d   = idx_q + 16'd1;
            if (idx_q == cnt_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            crst_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_HDR0;
          idx_d   = 16'd0;
          bcnt_d  = 2'd0;
          xor_d   = 8'd0;
          crst_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR0;
      idx_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = crst_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level model that
// predicts the memory writes and the load outcome.
module tb_imem_loader;
  localparam int SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  imem_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  logic [31:0] ea[$];
  logic [31:0] ed[$];
  logic [7:0]  strm[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Predicted writes from the stream; returns 1 if the load must fail.
  function automatic bit model(input logic [7:0] s[$]);
    int nw;
    logic [7:0] x;
    nw = int'(s[0]) + 256 * int'(s[1]);
    if (nw > SIZE) return 1'b1;
    for (int w = 0; w < nw; w++) begin
      ea.push_back(32'(w * 4));
      ed.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * nw; i++) x = x ^ s[i];
    return s[2+4*nw] != x;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (ea.size() == 0) begin
        vec++;
        miss++;
        $display("FAIL spurious_write: got addr %h data %h expected none",
                 mem_waddr, mem_wdata);
      end else begin
        chk("waddr", mem_waddr, ea.pop_front());
        chk("wdata", mem_wdata, ed.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    for (int t = 0; t < 20 && in_ready !== 1'b1; t++) @(negedge clk);
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_load(input int gapmax);
    bit err;
    int nw;
    int g;
    err = model(strm);
    nw = int'(strm[0]) + 256 * int'(strm[1]);
    for (int i = 0; i < strm.size(); i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      send(strm[i], g);
      if (nw <= SIZE && i >= 2 && i < 2 + 4 * nw && (i - 2) % 4 == 3)
        chk("we_latency", 32'(mem_we), 32'd1);
    end
    chk("done", 32'(done), 32'(!err));
    chk("error", 32'(error), 32'(err));
    chk("cpu_rst", 32'(cpu_rst), 32'(err));
    chk("ready_idle", 32'(in_ready), 32'd0);
    chk("writes_left", 32'(ea.size()), 32'd0);
  endtask

  task automatic do_reload(input logic with_byte);
    @(negedge clk);
    reload   = 1'b1;
    in_valid = with_byte;
    in_data  = 8'h02;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("reload_crst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_err", 32'(error), 32'd0);
    chk("reload_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic set_nominal();
    strm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h6f, 8'h00, 8'h00, 8'h00, 8'h6b};
  endtask

  initial begin
    bit e;
    #12;
    chk("rst_crst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    set_nominal();
    e = model(strm);
    chk("pin_ok", 32'(e), 32'd0);
    chk("pin_n", 32'(ea.size()), 32'd2);
    chk("pin_a0", ea[0], 32'h0);
    chk("pin_d0", ed[0], 32'h00100513);
    chk("pin_a1", ea[1], 32'h4);
    chk("pin_d1", ed[1], 32'h0000006f);
    ea.delete();
    ed.delete();

    run_load(0);

    do_reload(1'b0);
    run_load(5);

    do_reload(1'b0);
    strm[10] = 8'h6a;
    run_load(0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_nodone", 32'(done), 32'd0);
    chk("err_ready", 32'(in_ready), 32'd0);

    do_reload(1'b0);
    strm = '{8'h01, 8'h04};
    run_load(0);

    do_reload(1'b0);
    strm = '{8'h00, 8'h00, 8'h00};
    run_load(0);

    do_reload(1'b0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h05, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_crst", 32'(cpu_rst), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(error), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_waddr", mem_waddr, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    set_nominal();
    run_load(0);

    do_reload(1'b1);
    run_load(0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
